// File: rtl/pool_max.sv
// Streaming signed max-pool: groups accepted samples into windows of a run-time
// length and emits the signed maximum of each window over a valid/ready handshake.
module pool_max #(
  parameter int unsigned NUM_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bypass,
  input  logic [CNT_WIDTH-1:0] cfg_size,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [NUM_WIDTH-1:0] dn_data
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_sz;
  logic [NUM_WIDTH-1:0] r_acc;
  logic                 r_dn_valid;
  logic [NUM_WIDTH-1:0] r_dn_data;

  logic [CNT_WIDTH-1:0] w_len;
  logic [CNT_WIDTH-1:0] w_sz;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [NUM_WIDTH-1:0] w_max;
  logic                 w_first;
  logic                 w_final;
  logic                 w_accept;

  // Single output slot: a new beat is taken only if the slot is empty or draining.
  assign up_ready = !r_dn_valid || dn_ready;
  assign w_accept = up_valid && up_ready;
  assign dn_valid = r_dn_valid;
  assign dn_data  = r_dn_data;

  // Window length is only sampled on the first beat; later beats use the latched copy.
  always_comb begin
    w_first   = (r_cnt == '0);
    w_len     = (bypass || (cfg_size <= CNT_WIDTH'(1))) ? CNT_WIDTH'(1) : cfg_size;
    w_sz      = w_first ? w_len : r_sz;
    w_cnt_inc = r_cnt + CNT_WIDTH'(1);
    w_final   = (w_cnt_inc == w_sz);
    w_max     = up_data;
    if (!w_first && ($signed(r_acc) >= $signed(up_data))) begin
      w_max = r_acc;
    end
  end

  // Window counter, latched length and running maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sz  <= CNT_WIDTH'(1);
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_max;
      if (w_first) begin
        r_sz <= w_len;
      end
      if (w_final) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // Output slot: reload on a final beat, otherwise clear valid when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dn_valid <= 1'b0;
      r_dn_data  <= '0;
    end else if (w_accept && w_final) begin
      r_dn_valid <= 1'b1;
      r_dn_data  <= w_max;
    end else if (dn_ready) begin
      r_dn_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_max.sv
// Bench for pool_max: directed vector table, reset sequence and randomized
// traffic checked against a queue-based window-maximum model.
module tb_pool_max;

  localparam int unsigned NW = 16;
  localparam int unsigned CW = 4;

  typedef logic signed [NW-1:0] sample_t;

  typedef struct {
    logic          v;
    logic [NW-1:0] d;
    logic          byp;
    logic [CW-1:0] cfg;
    logic          rdy;
    logic          er;
    logic          ev;
    logic [NW-1:0] ed;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          bypass;
  logic [CW-1:0] cfg_size;
  logic          up_valid;
  logic          up_ready;
  logic [NW-1:0] up_data;
  logic          dn_valid;
  logic          dn_ready;
  logic [NW-1:0] dn_data;

  pool_max #(.NUM_WIDTH(NW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bypass   (bypass),
    .cfg_size (cfg_size),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_data  (dn_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: samples of the open window, its length, and the output slot.
  sample_t       wq[$];
  int            m_len = 1;
  logic          m_valid = 1'b0;
  logic [NW-1:0] m_data = '0;

  vec_t tbl[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    wq.delete();
    m_len   = 1;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // One clock: drive at edge+1, check up_ready, advance model, check outputs at edge+1.
  task automatic tick(input logic v, input logic [NW-1:0] d, input logic byp,
                      input logic [CW-1:0] cfg, input logic rdy, output logic rdy_seen);
    logic          fire;
    logic          fin;
    logic          nv;
    logic [NW-1:0] nd;
    sample_t       res;
    up_valid = v;
    up_data  = d;
    bypass   = byp;
    cfg_size = cfg;
    dn_ready = rdy;
    #1;
    rdy_seen = up_ready;
    chk("up_ready", {31'd0, up_ready}, {31'd0, (!m_valid || rdy)});
    fire = v && (!m_valid || rdy);
    fin  = 1'b0;
    res  = '0;
    nv   = m_valid;
    nd   = m_data;
    if (fire) begin
      if (wq.size() == 0) m_len = (byp || cfg <= 1) ? 1 : int'(cfg);
      wq.push_back(sample_t'(d));
      if (wq.size() == m_len) begin
        res = wq[0];
        foreach (wq[k]) if (wq[k] > res) res = wq[k];
        fin = 1'b1;
        wq.delete();
      end
    end
    if (fin) begin
      nv = 1'b1;
      nd = res;
    end else if (m_valid && rdy) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = nv;
    m_data  = nd;
    chk("dn_valid", {31'd0, dn_valid}, {31'd0, m_valid});
    chk("dn_data", {16'd0, dn_data}, {16'd0, m_data});
  endtask

  logic          rs;
  logic [NW-1:0] rd;
  logic          rv;

  initial begin
    rst_n    = 1'b0;
    bypass   = 1'b0;
    cfg_size = '0;
    up_valid = 1'b0;
    up_data  = '0;
    dn_ready = 1'b0;
    #3;
    chk("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("rst_dn_data", {16'd0, dn_data}, 32'd0);
    chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //          v     d         byp   cfg   rdy   er    ev    ed
    tbl[0]  = '{1'b1, 16'hF580, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 16'hF680, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 16'h0200, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 16'hFF00, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0200};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[5]  = '{1'b1, 16'hFD00, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 16'hFD00};
    tbl[6]  = '{1'b1, 16'h0480, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0480};
    tbl[7]  = '{1'b1, 16'h0000, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[8]  = '{1'b1, 16'hFD00, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 16'hFD00};
    tbl[9]  = '{1'b1, 16'h0480, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 16'h0480};
    tbl[10] = '{1'b1, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[12] = '{1'b1, 16'h8000, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 16'h7FFF, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'h7FFF};
    tbl[14] = '{1'b1, 16'h8000, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 16'h7FFF};
    tbl[15] = '{1'b1, 16'h8000, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 16'h8000};
    tbl[16] = '{1'b1, 16'h0100, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 16'h8000};
    tbl[17] = '{1'b1, 16'h0200, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 16'h0200};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[19] = '{1'b1, 16'h0100, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 16'h0100};
    tbl[20] = '{1'b1, 16'h0200, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0100};
    tbl[21] = '{1'b1, 16'h0200, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0100};
    tbl[22] = '{1'b1, 16'h0200, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 16'h0200};
    tbl[23] = '{1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[24] = '{1'b1, 16'h0500, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[25] = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[26] = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[27] = '{1'b1, 16'h0600, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[28] = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0200};
    tbl[29] = '{1'b1, 16'h0400, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 16'h0600};
    tbl[30] = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0600};

    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].byp, tbl[i].cfg, tbl[i].rdy, rs);
      chk($sformatf("tbl%0d_ready", i), {31'd0, rs}, {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d_valid", i), {31'd0, dn_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_data", i), {16'd0, dn_data}, {16'd0, tbl[i].ed});
    end

    // Reset in the middle of a 3-sample window; that partial window must be discarded.
    tick(1'b1, 16'h0500, 1'b0, 4'd3, 1'b1, rs);
    up_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("midrst_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("midrst_dn_data", {16'd0, dn_data}, 32'd0);
    chk("midrst_up_ready", {31'd0, up_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    tick(1'b1, 16'h0100, 1'b0, 4'd2, 1'b1, rs);
    chk("post_rst_beat1_valid", {31'd0, dn_valid}, 32'd0);
    tick(1'b1, 16'h0300, 1'b0, 4'd2, 1'b1, rs);
    chk("post_rst_result_valid", {31'd0, dn_valid}, 32'd1);
    chk("post_rst_result_data", {16'd0, dn_data}, 32'h0300);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       rd = 16'h8000;
        1:       rd = 16'h7FFF;
        default: rd = NW'($urandom);
      endcase
      rv = ($urandom_range(0, 4) != 0);
      tick(rv, rd, ($urandom_range(0, 7) == 0),
           (($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 5))),
           ($urandom_range(0, 3) != 0), rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_max.md
# pool_max

Streaming signed max-pool stage that sits directly downstream of `relu`, consuming its `dn_data` activation stream. It groups consecutive accepted samples into windows of a run-time-selected length and emits one result per window: the signed maximum of that window. It uses a valid/ready handshake on both sides so the convolution output path can be stalled. A `bypass` input forces a window length of 1, so samples pass through unchanged, matching the bypass semantics of the activation stage.

## Interface
- `NUM_WIDTH`, 16, width of signed two's-complement data (Q8.8 in the default configuration).
- `CNT_WIDTH`, 4, width of the window-length configuration and the internal sample counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `bypass`  in  1  when high at the first beat of a window, the window length is 1.
- `cfg_size`  in  CNT_WIDTH  window length in samples; values 0 and 1 both mean length 1.
- `up_valid`  in  1  upstream sample valid.
- `up_ready`  out  1  upstream sample accepted when `up_valid & up_ready`.
- `up_data`  in  NUM_WIDTH  signed upstream sample.
- `dn_valid`  out  1  result valid.
- `dn_ready`  in  1  result consumed when `dn_valid & dn_ready`.
- `dn_data`  out  NUM_WIDTH  signed window maximum.

## Operation
- State:
  - `cnt` (CNT_WIDTH): number of samples accepted in the current window.
  - `sz` (CNT_WIDTH): latched window length.
  - `acc` (NUM_WIDTH, signed): running maximum.
  - Output register holding `dn_valid` and `dn_data`.
- Effective length: `len = (bypass | cfg_size <= 1) ? 1 : cfg_size`.
  - Sampled only on an accepted beat while `cnt == 0`, and latched into `sz`.
  - Changes to `bypass` or `cfg_size` mid-window have no effect until the next window starts.
- Window states, implicit in `cnt`:
  - IDLE/FIRST (`cnt == 0`).
  - ACCUM (`0 < cnt < sz`).
- Accepted beat with `cnt == 0`:
  - `acc <= up_data`.
  - `sz <= len`.
  - If `len == 1`, the beat is also the final beat.
- Accepted beat with `cnt > 0`: `acc <= max(acc, up_data)`, using a signed comparison over the full width.
- Final beat (the beat that makes the count reach `sz`):
  - `dn_data <= max(acc, up_data)`, or `up_data` when it is also the first beat.
  - `dn_valid <= 1`.
  - `cnt <= 0`.
- Non-final beat: `cnt <= cnt + 1`.
- Compare rules:
  - Ties keep the earlier value; the result is the same value either way.
  - The most negative value (`1` followed by zeros) compares below all others.
  - The most positive value (`0` followed by ones) compares above all others.
  - No arithmetic is performed, so there is no overflow path.
- `up_ready = !dn_valid | dn_ready`, combinational.
  - Applies to every beat, not only final beats.
  - The block holds no data beyond `acc` and one output register.
- Output drain: `dn_valid & dn_ready` with no new final beat in the same cycle gives `dn_valid <= 0`.
  - `dn_data` holds its last value after draining.
- Simultaneous drain and final beat: the output register reloads and `dn_valid` stays 1, giving back-to-back results.
- While `dn_valid & !dn_ready`, `dn_data` and `dn_valid` are stable.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `dn_valid = 0`, `dn_data = 0`, `cnt = 0`, `sz = 1`, `acc = 0`.
  - `up_ready = 1`, because `dn_valid` is 0.
- Reset mid-window discards the partial window.
  - The first accepted beat after `rst_n` rises starts a new window.
- Latency: `dn_valid` rises on the first rising edge after the final beat is accepted.
- Throughput: one sample per cycle while `dn_ready` is held high.
  - With `len == 1`, one result per cycle.
- Backpressure: `dn_ready` low while `dn_valid` is high drops `up_ready` in the same cycle.
  - Upstream must hold `up_data` until accepted.
- `up_valid` low cycles are bubbles and do not advance `cnt`.

## Test plan
- Reset:
  - Stimulus: assert `rst_n = 0` mid-stream, then release it.
  - Required response: `dn_valid = 0`, `dn_data = 0`, `up_ready = 1`.
  - The next 2 beats, 1.0 and 3.0 with `cfg_size = 2`, give one result of 3.0.
- Window of 4:
  - Stimulus: `cfg_size = 4`, `dn_ready = 1`, beats -10.5, -9.5, 2.0, -1.0 back-to-back.
  - Required response: one `dn_valid` pulse carrying 2.0, one cycle after the 4th beat.
- Bypass and length 0:
  - Stimulus: `bypass = 1`, then separately `cfg_size = 0`; beats -3.0, 4.5, 0.0.
  - Required response: three results -3.0, 4.5, 0.0 on consecutive cycles.
- Extremes and mid-window configuration change:
  - Stimulus: `cfg_size = 2`, beats `NUM_MIN`, `NUM_MAX`, then `NUM_MIN`, `NUM_MIN`.
  - Required response: results `NUM_MAX` then `NUM_MIN`.
  - Stimulus: change `cfg_size` to 3 after the 1st beat of a window.
  - Required response: that window still closes after 2 beats.
- Backpressure:
  - Stimulus: `cfg_size = 1`, `dn_ready = 0`, beats 1.0 and 2.0 offered.
  - Required response: result 1.0 held, `up_ready = 0`, 2.0 not accepted.
  - Stimulus: raise `dn_ready` for 1 cycle.
  - Required response: 1.0 drains and 2.0 is accepted in the same cycle; 2.0 is presented next cycle; no sample is lost or duplicated.
- Bubbles:
  - Stimulus: `cfg_size = 3`, beats 5.0, idle ×2, 6.0, idle, 4.0.
  - Required response: a single result 6.0, one cycle after the 4.0 beat.
